// File: rtl/demux_register_pkg.sv
// ---------------------------------------------------------------------------
// demux_register_pkg
//   Shared definitions for the registered 1-to-2 demultiplexer.
//   SEL_CH1 / SEL_CH2 : select encoding, identical to the 2-to-1 mux-register
//                       on the producer side of the datapath.
//   DEFAULT_WIDTH     : default data word width.
//   DEFAULT_DEPTH     : default entries per channel FIFO.
// ---------------------------------------------------------------------------
package demux_register_pkg;

  localparam logic SEL_CH1       = 1'b0;
  localparam logic SEL_CH2       = 1'b1;
  localparam int   DEFAULT_WIDTH = 3;
  localparam int   DEFAULT_DEPTH = 2;

endpackage : demux_register_pkg

// File: rtl/demux_fifo_ch.sv
// ---------------------------------------------------------------------------
// demux_fifo_ch
//   One output channel of the demultiplexer: a small synchronous FIFO.
//   Ports:
//     clk, reset : rising-edge clock, synchronous active-high reset
//     push, din  : write request and data; ignored while full
//     full       : occupancy equals DEPTH
//     pop        : consumer ready; ignored while empty
//     dout       : head-of-queue word, forced to 0 while empty
//     valid      : at least one word is held
//     level      : occupancy, 0..DEPTH
//
//   Handshake: a transfer happens on a rising edge exactly when the
//   valid-side and ready-side signals are both high at that edge. On the
//   write side "valid" is push and "ready" is !full; on the read side
//   "valid" is valid and "ready" is pop. Neither ready depends on its
//   matching valid.
// ---------------------------------------------------------------------------
module demux_fifo_ch #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign valid   = (count != '0);
  assign level   = count;
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  // Storage is only observable through the masked head word, so it needs
  // no reset.
  assign dout = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the natural rollover of the PTR_W-bit
  // pointers is exactly the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : demux_fifo_ch

// File: rtl/demux_register.sv
// ---------------------------------------------------------------------------
// demux_register
//   Registered 1-to-2 demultiplexer. One producer stream is steered by sel
//   into one of two independent FIFO-buffered output channels.
//   Ports:
//     clk, reset           : rising-edge clock, synchronous active-high reset
//     d_in, sel, in_valid  : producer word, channel select, word present
//     in_ready             : selected channel is not full (combinational,
//                            independent of in_valid)
//     d_out1, out1_valid,  : channel 1 head word (0 when empty), non-empty
//     out1_ready           : flag, consumer accept
//     d_out2, out2_valid,  : channel 2, same meaning
//     out2_ready
//     level1, level2       : channel occupancies, 0..DEPTH
//
//   Handshake: every transfer (producer push, per-channel pop) occurs on a
//   rising edge where its valid and ready are both high; ready never
//   depends on valid, and a full channel offers no same-cycle pass-through.
// ---------------------------------------------------------------------------
module demux_register
  import demux_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d_out1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] d_out2,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [LVL_W-1:0] level1,
  output logic [LVL_W-1:0] level2
);

  logic full1;
  logic full2;
  logic push1;
  logic push2;

  assign in_ready = (sel == SEL_CH1) ? ~full1 : ~full2;

  // Only the selected channel ever sees a push.
  assign push1 = in_valid & in_ready & (sel == SEL_CH1);
  assign push2 = in_valid & in_ready & (sel == SEL_CH2);

  demux_fifo_ch #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_ch1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .din   (d_in),
    .full  (full1),
    .pop   (out1_ready),
    .dout  (d_out1),
    .valid (out1_valid),
    .level (level1)
  );

  demux_fifo_ch #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_ch2 (
    .clk   (clk),
    .reset (reset),
    .push  (push2),
    .din   (d_in),
    .full  (full2),
    .pop   (out2_ready),
    .dout  (d_out2),
    .valid (out2_valid),
    .level (level2)
  );

endmodule : demux_register

// File: tb/tb_demux_register.sv
module tb_demux_register;

  localparam int W = 3;
  localparam int D = 2;
  localparam int L = 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] d_in;
  logic         sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] d_out1;
  logic         out1_valid;
  logic         out1_ready;
  logic [W-1:0] d_out2;
  logic         out2_valid;
  logic         out2_ready;
  logic [L-1:0] level1;
  logic [L-1:0] level2;

  always #5 clk = ~clk;

  demux_register #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_in       (d_in),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d_out1     (d_out1),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .d_out2     (d_out2),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .level1     (level1),
    .level2     (level2)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  int total = 0;
  int bad   = 0;

  // Drive inputs away from the clock edge and let them settle.
  task automatic drive(input logic r, input logic s, input logic v,
                       input logic [W-1:0] d, input logic r1, input logic r2);
    reset      = r;
    sel        = s;
    in_valid   = v;
    d_in       = d;
    out1_ready = r1;
    out2_ready = r2;
    #1;
  endtask

  // Advance one clock and apply the same transfer rules to the queues.
  task automatic step();
    logic acc;
    logic p1;
    logic p2;
    acc = in_valid && (sel ? (exp_q2.size() < D) : (exp_q1.size() < D));
    p1  = out1_ready && (exp_q1.size() > 0);
    p2  = out2_ready && (exp_q2.size() > 0);
    @(posedge clk);
    if (reset) begin
      exp_q1.delete();
      exp_q2.delete();
    end else begin
      if (p1) void'(exp_q1.pop_front());
      if (p2) void'(exp_q2.pop_front());
      if (acc) begin
        if (sel) exp_q2.push_back(d_in);
        else     exp_q1.push_back(d_in);
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1, 0, 0, '0, 0, 0);
    step();
    step();
    drive(0, 0, 0, '0, 0, 0);
    total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL reset_v1 got=%b exp=0", out1_valid); end
    total++; if (out2_valid !== 1'b0) begin bad++; $display("FAIL reset_v2 got=%b exp=0", out2_valid); end
    total++; if (level1 !== 2'd0) begin bad++; $display("FAIL reset_l1 got=%0d exp=0", level1); end
    total++; if (level2 !== 2'd0) begin bad++; $display("FAIL reset_l2 got=%0d exp=0", level2); end
    total++; if (d_out1 !== 3'b000) begin bad++; $display("FAIL reset_d1 got=%b exp=000", d_out1); end
    total++; if (d_out2 !== 3'b000) begin bad++; $display("FAIL reset_d2 got=%b exp=000", d_out2); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    drive(0, 0, 1, 3'b101, 0, 0);
    step();
    total++; if (d_out1 !== 3'b101 || out1_valid !== 1'b1) begin bad++; $display("FAIL basic_lat1 got=%b/%b exp=101/1", d_out1, out1_valid); end
    drive(0, 1, 1, 3'b011, 0, 0);
    step();
    drive(0, 0, 0, '0, 0, 0);
    total++; if (d_out1 !== 3'b101 || out1_valid !== 1'b1) begin bad++; $display("FAIL basic_ch1 got=%b/%b exp=101/1", d_out1, out1_valid); end
    total++; if (d_out2 !== 3'b011 || out2_valid !== 1'b1) begin bad++; $display("FAIL basic_ch2 got=%b/%b exp=011/1", d_out2, out2_valid); end
    total++; if (level1 !== 2'd1 || level2 !== 2'd1) begin bad++; $display("FAIL basic_lvl got=%0d/%0d exp=1/1", level1, level2); end
    drive(0, 0, 0, '0, 1, 1);
    step();
    total++; if (level1 !== 2'd0 || level2 !== 2'd0) begin bad++; $display("FAIL basic_drain got=%0d/%0d exp=0/0", level1, level2); end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 1, 3'b001, 0, 0);
    step();
    drive(0, 0, 1, 3'b010, 0, 0);
    step();
    drive(0, 0, 1, 3'b100, 0, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_rdy got=%b exp=0", in_ready); end
    total++; if (level1 !== 2'd2) begin bad++; $display("FAIL b2b_full_lvl got=%0d exp=2", level1); end
    step();
    total++; if (level1 !== 2'd2 || d_out1 !== 3'b001) begin bad++; $display("FAIL b2b_stall got=%0d/%b exp=2/001", level1, d_out1); end
    drive(0, 0, 1, 3'b100, 1, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_nopass got=%b exp=0", in_ready); end
    step();
    total++; if (d_out1 !== 3'b010 || level1 !== 2'd1) begin bad++; $display("FAIL b2b_pop1 got=%b/%0d exp=010/1", d_out1, level1); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_freed got=%b exp=1", in_ready); end
    step();
    drive(0, 0, 0, '0, 0, 0);
    total++; if (d_out1 !== 3'b100 || level1 !== 2'd1) begin bad++; $display("FAIL b2b_last got=%b/%0d exp=100/1", d_out1, level1); end
  endtask

  task automatic test_cross_channel();
    drive(0, 0, 1, 3'b110, 0, 0);
    step();
    drive(0, 1, 1, 3'b111, 0, 0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL cross_rdy got=%b exp=1", in_ready); end
    step();
    drive(0, 0, 0, '0, 0, 0);
    total++; if (d_out2 !== 3'b111 || out2_valid !== 1'b1) begin bad++; $display("FAIL cross_d2 got=%b/%b exp=111/1", d_out2, out2_valid); end
    total++; if (level1 !== 2'd2 || d_out1 !== 3'b100) begin bad++; $display("FAIL cross_ch1 got=%0d/%b exp=2/100", level1, d_out1); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] last;
    logic [W-1:0] w;
    drive(0, 0, 0, '0, 1, 1);
    for (int i = 0; i < 3; i++) step();
    total++; if (level1 !== 2'd0 || level2 !== 2'd0) begin bad++; $display("FAIL wrap_empty got=%0d/%0d exp=0/0", level1, level2); end
    drive(0, 0, 1, 3'b110, 0, 0);
    step();
    last = 3'b110;
    for (int i = 0; i < 6; i++) begin
      w = (i == 0) ? 3'b001 : W'($urandom_range(0, 7));
      drive(0, 0, 1, w, 1, 0);
      total++; if (in_ready !== 1'b1 || d_out1 !== last) begin bad++; $display("FAIL wrap_pre%0d got=%b/%b exp=1/%b", i, in_ready, d_out1, last); end
      step();
      total++; if (level1 !== 2'd1 || d_out1 !== w) begin bad++; $display("FAIL wrap_post%0d got=%0d/%b exp=1/%b", i, level1, d_out1, w); end
      last = w;
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 3'b010, 0, 0);
    step();
    drive(0, 1, 1, 3'b011, 0, 0);
    step();
    drive(0, 1, 1, 3'b100, 0, 0);
    step();
    total++; if (level1 !== 2'd2 || level2 !== 2'd2) begin bad++; $display("FAIL rmid_fill got=%0d/%0d exp=2/2", level1, level2); end
    drive(1, 0, 1, 3'b101, 0, 0);
    step();
    drive(0, 0, 0, '0, 0, 0);
    total++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b/%b exp=0/0", out1_valid, out2_valid); end
    total++; if (level1 !== 2'd0 || level2 !== 2'd0) begin bad++; $display("FAIL rmid_lvl got=%0d/%0d exp=0/0", level1, level2); end
    total++; if (d_out1 !== 3'b000 || d_out2 !== 3'b000) begin bad++; $display("FAIL rmid_data got=%b/%b exp=000/000", d_out1, d_out2); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_rdy got=%b exp=1", in_ready); end
  endtask

  task automatic test_random();
    logic         exp_rdy;
    logic [W-1:0] exp_d1;
    logic [W-1:0] exp_d2;
    for (int n = 0; n < 2000; n++) begin
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp_rdy = sel ? (exp_q2.size() < D) : (exp_q1.size() < D);
      exp_d1  = (exp_q1.size() > 0) ? exp_q1[0] : '0;
      exp_d2  = (exp_q2.size() > 0) ? exp_q2[0] : '0;
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_rdy n=%0d got=%b exp=%b", n, in_ready, exp_rdy); end
      total++; if (d_out1 !== exp_d1 || out1_valid !== (exp_q1.size() > 0)) begin bad++; $display("FAIL rnd_ch1 n=%0d got=%b/%b exp=%b/%0d", n, d_out1, out1_valid, exp_d1, exp_q1.size()); end
      total++; if (d_out2 !== exp_d2 || out2_valid !== (exp_q2.size() > 0)) begin bad++; $display("FAIL rnd_ch2 n=%0d got=%b/%b exp=%b/%0d", n, d_out2, out2_valid, exp_d2, exp_q2.size()); end
      total++; if (int'(level1) != exp_q1.size() || int'(level2) != exp_q2.size() || level1 > 2'd2 || level2 > 2'd2) begin bad++; $display("FAIL rnd_lvl n=%0d got=%0d/%0d exp=%0d/%0d", n, level1, level2, exp_q1.size(), exp_q2.size()); end
      step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_cross_channel();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule : tb_demux_register
